// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: redirect controls in, PC/EPC/RAS status out.
// master = pipeline control driving redirects; slave = pc_sequencer.
interface pc_sequencer_if;
  logic        stall_i;
  logic        branch_taken_i;
  logic [15:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_field_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        link_i;
  logic        ret_i;
  logic        exc_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] epc_o;
  logic        misalign_o;
  logic        ras_hit_o;
  logic        ras_miss_o;
  logic        ras_empty_o;

  modport master (
    output stall_i, branch_taken_i, branch_offset_i,
    output jump_i, jump_field_i, jr_i, jr_target_i,
    output link_i, ret_i, exc_i,
    input  pc_o, pc_plus4_o, epc_o, misalign_o,
    input  ras_hit_o, ras_miss_o, ras_empty_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_offset_i,
    input  jump_i, jump_field_i, jr_i, jr_target_i,
    input  link_i, ret_i, exc_i,
    output pc_o, pc_plus4_o, epc_o, misalign_o,
    output ras_hit_o, ras_miss_o, ras_empty_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC register + next-PC select (exc > jr > j > branch > seq), EPC, misalign pulse.
// Ports: clk, rst_n (async low), bus (pc_sequencer_if.slave). Macro PC_SEQ_RAS_EN adds RAS.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        mis_q, mis_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        adv, jr_ok;
  logic        sel_exc, sel_hold, sel_jr;
  logic        sel_j, sel_br, sel_seq;
  logic        ras_push, ras_pop;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 +
    {{14{bus.branch_offset_i[15]}},
     bus.branch_offset_i, 2'b00};
  assign j_tgt    = {pc_plus4[31:28],
                     bus.jump_field_i, 2'b00};
  assign jr_ok    = bus.jr_target_i[1:0] == 2'b00;

  // One-hot source select; priority is
  // folded in here so the decoder is exclusive.
  assign adv      = !bus.exc_i && !bus.stall_i;
  assign sel_exc  = bus.exc_i;
  assign sel_hold = !bus.exc_i && bus.stall_i;
  assign sel_jr   = adv && bus.jr_i;
  assign sel_j    = adv && !bus.jr_i && bus.jump_i;
  assign sel_br   = adv && !bus.jr_i && !bus.jump_i
                    && bus.branch_taken_i;
  assign sel_seq  = adv && !bus.jr_i && !bus.jump_i
                    && !bus.branch_taken_i;

  assign ras_push = sel_j && bus.link_i;
  assign ras_pop  = sel_jr && jr_ok && bus.ret_i;

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    mis_d = 1'b0;
    unique case (1'b1)
      sel_exc: begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
      end
      sel_hold: pc_d = pc_q;
      sel_jr: begin
        if (jr_ok) begin
          pc_d = bus.jr_target_i;
        end else begin
          pc_d  = EXC_VECTOR;
          epc_d = pc_q;
          mis_d = 1'b1;
        end
      end
      sel_j:   pc_d = j_tgt;
      sel_br:  pc_d = br_tgt;
      sel_seq: pc_d = pc_plus4;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_plus4;
  assign bus.epc_o      = epc_q;
  assign bus.misalign_o = mis_q;

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] top;
  logic [PW:0]   cnt_q;
  logic          hit_q, miss_q;

  // ptr_q is the next write slot; when full
  // it also addresses the oldest entry.
  assign top = ptr_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      if (ras_push) begin
        ras_q[ptr_q] <= pc_plus4;
        ptr_q        <= ptr_q + 1'b1;
        if (cnt_q != FULL)
          cnt_q <= cnt_q + 1'b1;
      end else if (ras_pop) begin
        if (cnt_q == '0) begin
          miss_q <= 1'b1;
        end else begin
          hit_q  <= ras_q[top] == bus.jr_target_i;
          miss_q <= ras_q[top] != bus.jr_target_i;
          ptr_q  <= top;
          cnt_q  <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.ras_hit_o   = hit_q;
  assign bus.ras_miss_o  = miss_q;
  assign bus.ras_empty_o = cnt_q == '0;
`else
  logic unused_ras;
  assign unused_ras      = ^{ras_push, ras_pop};
  assign bus.ras_hit_o   = 1'b0;
  assign bus.ras_miss_o  = 1'b0;
  assign bus.ras_empty_o = 1'b1;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, RAS sequences, random vs. model.
// Works with and without PC_SEQ_RAS_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h8000_0180;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .EXC_VECTOR  (EV),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_epc;
  bit          m_mis, m_hit, m_miss;
  logic [31:0] m_ras[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic void model_reset();
    m_pc   = RV;
    m_epc  = '0;
    m_mis  = 0;
    m_hit  = 0;
    m_miss = 0;
    m_ras.delete();
  endfunction

  function automatic void model_step(
    bit st, bit br, logic [15:0] off, bit jp,
    logic [25:0] fld, bit jr, logic [31:0] tgt,
    bit lk, bit rt, bit ex);
    logic [31:0] pc4, t;
    int o;
    pc4    = m_pc + 32'd4;
    m_mis  = 0;
    m_hit  = 0;
    m_miss = 0;
    if (ex) begin
      m_epc = m_pc;
      m_pc  = EV;
    end else if (st) begin
      m_pc = m_pc;
    end else if (jr) begin
      if (tgt % 4 == 0) begin
        m_pc = tgt;
        if (RAS_ON && rt) begin
          if (m_ras.size() == 0) begin
            m_miss = 1;
          end else begin
            t      = m_ras.pop_back();
            m_hit  = (t == tgt);
            m_miss = !m_hit;
          end
        end
      end else begin
        m_epc = m_pc;
        m_pc  = EV;
        m_mis = 1;
      end
    end else if (jp) begin
      if (RAS_ON && lk) begin
        m_ras.push_back(pc4);
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end
      m_pc = {pc4[31:28], fld, 2'b00};
    end else if (br) begin
      o    = int'($signed(off));
      m_pc = pc4 + 32'(o * 4);
    end else begin
      m_pc = pc4;
    end
  endfunction

  task automatic check_all();
    chk("pc", bus.pc_o, m_pc);
    chk("epc", bus.epc_o, m_epc);
    chk1("misalign", bus.misalign_o, m_mis);
    chk1("ras_hit", bus.ras_hit_o, m_hit);
    chk1("ras_miss", bus.ras_miss_o, m_miss);
    chk1("ras_empty", bus.ras_empty_o,
         m_ras.size() == 0);
  endtask

  task automatic step(
    input bit st, input bit br,
    input logic [15:0] off, input bit jp,
    input logic [25:0] fld, input bit jr,
    input logic [31:0] tgt, input bit lk,
    input bit rt, input bit ex);
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_offset_i = off;
    bus.jump_i          = jp;
    bus.jump_field_i    = fld;
    bus.jr_i            = jr;
    bus.jr_target_i     = tgt;
    bus.link_i          = lk;
    bus.ret_i           = rt;
    bus.exc_i           = ex;
    #1;
    chk("pc_plus4", bus.pc_plus4_o, m_pc + 32'd4);
    @(posedge clk);
    model_step(st, br, off, jp, fld, jr, tgt,
               lk, rt, ex);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic go(input logic [31:0] a);
    step(0, 0, '0, 0, '0, 1, a, 0, 0, 0);
  endtask

  task automatic jal(input logic [31:0] dst);
    step(0, 0, '0, 1, dst[27:2], 0, '0, 1, 0, 0);
  endtask

  task automatic ret(input logic [31:0] a);
    step(0, 0, '0, 0, '0, 1, a, 0, 1, 0);
  endtask

  typedef struct {
    bit          st;
    bit          br;
    logic [15:0] off;
    bit          jp;
    logic [25:0] fld;
    bit          jr;
    logic [31:0] tgt;
    bit          ex;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    bit          e_mis;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall_i         = 0;
    bus.branch_taken_i  = 0;
    bus.branch_offset_i = '0;
    bus.jump_i          = 0;
    bus.jump_field_i    = '0;
    bus.jr_i            = 0;
    bus.jr_target_i     = '0;
    bus.link_i          = 0;
    bus.ret_i           = 0;
    bus.exc_i           = 0;

    // st br off jp fld jr tgt ex | pc epc mis
    tbl.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,
                    32'h4,32'h0,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,
                    32'h8,32'h0,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,
                    32'hC,32'h0,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,
                    32'h0040_0010,0,
                    32'h0040_0010,32'h0,0});
    tbl.push_back('{1,0,16'h0,1,26'h010_0040,0,
                    32'h0,0,32'h0040_0010,32'h0,0});
    tbl.push_back('{0,0,16'h0,1,26'h010_0040,0,
                    32'h0,0,32'h0040_0100,32'h0,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,32'h100,0,
                    32'h100,32'h0,0});
    tbl.push_back('{0,1,16'hFFFE,0,26'h0,0,32'h0,1,
                    32'h8000_0180,32'h100,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,32'h100,0,
                    32'h100,32'h100,0});
    tbl.push_back('{0,1,16'hFFFE,0,26'h0,0,32'h0,0,
                    32'hFC,32'h100,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,32'h200,0,
                    32'h200,32'h100,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,32'h1002,0,
                    32'h8000_0180,32'h200,1});
    tbl.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,
                    32'h8000_0184,32'h200,0});
    tbl.push_back('{1,0,16'h0,0,26'h0,0,32'h0,1,
                    32'h8000_0180,32'h8000_0184,0});
    tbl.push_back('{1,0,16'h0,0,26'h0,1,32'h1002,0,
                    32'h8000_0180,32'h8000_0184,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,
                    32'hFFFF_FFFC,0,
                    32'hFFFF_FFFC,32'h8000_0184,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,
                    32'h0,32'h8000_0184,0});
    tbl.push_back('{0,0,16'h0,0,26'h0,1,
                    32'h7FFF_FFFC,0,
                    32'h7FFF_FFFC,32'h8000_0184,0});
    tbl.push_back('{0,0,16'h0,1,26'h3FF_FFFF,0,
                    32'h0,0,32'h8FFF_FFFC,
                    32'h8000_0184,0});
    tbl.push_back('{0,1,16'h8000,0,26'h0,0,32'h0,0,
                    32'h8FFE_0000,32'h8000_0184,0});
    tbl.push_back('{0,1,16'h0001,1,26'h000_0010,0,
                    32'h0,0,32'h8000_0040,
                    32'h8000_0184,0});
    tbl.push_back('{0,1,16'h0001,1,26'h000_0010,1,
                    32'h400,0,32'h400,
                    32'h8000_0184,0});

    // reset state
    #12;
    model_reset();
    chk("rst_pc", bus.pc_o, RV);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk1("rst_empty", bus.ras_empty_o, 1'b1);
    check_all();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].br, tbl[i].off,
           tbl[i].jp, tbl[i].fld, tbl[i].jr,
           tbl[i].tgt, 0, 0, tbl[i].ex);
      chk("tbl_pc", bus.pc_o, tbl[i].e_pc);
      chk("tbl_epc", bus.epc_o, tbl[i].e_epc);
      chk1("tbl_mis", bus.misalign_o, tbl[i].e_mis);
    end

    // jal / jr $ra pairing
    go(32'h300);
    jal(32'h600);
    chk1("ras_nonempty", bus.ras_empty_o, !RAS_ON);
    ret(32'h304);
    chk1("ret_hit", bus.ras_hit_o, RAS_ON);
    chk1("ret_hit_nomiss", bus.ras_miss_o, 1'b0);
    idle();
    chk1("hit_one_cycle", bus.ras_hit_o, 1'b0);
    go(32'h300);
    jal(32'h600);
    ret(32'h308);
    chk1("ret_miss", bus.ras_miss_o, RAS_ON);
    chk1("ret_miss_nohit", bus.ras_hit_o, 1'b0);

    // stalled jal, stray link/ret: no RAS effect
    step(1, 0, '0, 1, 26'h100, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, '0, 0, '0, 1, 1, 0);
    chk1("stray_empty", bus.ras_empty_o, 1'b1);

    // overflow: five jals, five returns
    go(32'h1000);
    for (int k = 0; k < 5; k++)
      jal(32'h1100 + 32'(k) * 32'h100);
    for (int k = 0; k < 4; k++) begin
      ret(32'h1404 - 32'(k) * 32'h100);
      chk1("ovf_hit", bus.ras_hit_o, RAS_ON);
    end
    ret(32'h1004);
    chk1("ovf_empty_miss", bus.ras_miss_o, RAS_ON);
    chk1("ovf_empty", bus.ras_empty_o, 1'b1);

    // reset mid-stream discards RAS
    jal(32'h2000);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("async_rst_pc", bus.pc_o, RV);
    check_all();
    rst_n = 1'b1;
    idle();
    chk("post_rst_pc", bus.pc_o, RV + 32'd4);

    // randomized against the model
    for (int i = 0; i < 3000; i++) begin
      bit st, br, jp, jr, lk, rt, ex;
      logic [31:0] tgt;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        rst_n = 1'b1;
      end
      st = $urandom_range(0, 7) == 0;
      ex = $urandom_range(0, 15) == 0;
      jr = $urandom_range(0, 4) == 0;
      jp = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 3) == 0;
      lk = $urandom_range(0, 1) == 1;
      rt = $urandom_range(0, 1) == 1;
      if (rt && m_ras.size() > 0 &&
          $urandom_range(0, 1) == 1) begin
        tgt = m_ras[$];
      end else begin
        tgt = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0)
          tgt[1:0] = 2'($urandom_range(1, 3));
      end
      step(st, br, 16'($urandom()), jp,
           26'($urandom()), jr, tgt, lk, rt, ex);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
